// File: rtl/fb_pkg.sv
// Shared types and default geometry for the double-buffered framebuffer.
package fb_pkg;

  localparam int unsigned DATA_W_DEF = 1;
  localparam int unsigned ADDR_W_DEF = 17;
  localparam int unsigned DEPTH_DEF  = 76800;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_CLEAR     = 2'd2
  } fb_state_e;

endpackage

// File: rtl/fb_dp_ram.sv
// One framebuffer bank: a single write port and two registered read ports.
// Out-of-range writes are dropped and out-of-range reads return zero.
module fb_dp_ram
  import fb_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr0,
  output logic [DATA_W-1:0] rdata0,
  input  logic [ADDR_W-1:0] raddr1,
  output logic [DATA_W-1:0] rdata1
);

  localparam int unsigned       IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]   LIMIT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic w_ok_c, r0_ok_c, r1_ok_c;

  assign w_ok_c  = ({1'b0, waddr}  < LIMIT);
  assign r0_ok_c = ({1'b0, raddr0} < LIMIT);
  assign r1_ok_c = ({1'b0, raddr1} < LIMIT);

  // Storage has no reset; read ports are read-first.
  always_ff @(posedge clk) begin
    if (we && w_ok_c) begin
      mem[IDX_W'(waddr)] <= wdata;
    end
    rdata0 <= r0_ok_c ? mem[IDX_W'(raddr0)] : '0;
    rdata1 <= r1_ok_c ? mem[IDX_W'(raddr1)] : '0;
  end

endmodule

// File: rtl/dbuf_framebuffer_ctrl.sv
// Double-buffered framebuffer with a frame-synchronised swap handshake.
// Define FB_CLEAR_ON_SWAP_EN to zero the new back bank after every swap.
module dbuf_framebuffer_ctrl
  import fb_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned DEPTH    = DEPTH_DEF,
  parameter bit          INIT_SEL = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic              a_we,
  output logic              a_ready,
  output logic [DATA_W-1:0] a_rdata,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_rdata,
  input  logic              swap_req,
  input  logic              frame_sync,
  output logic              swap_ack,
  output logic              front_sel,
  output logic              clr_busy
);

  fb_state_e state_q, state_d;
  logic      front_sel_d, swap_ack_d, do_swap_c;
  logic      rd_sel_q;

  logic              wr_en_c;
  logic [ADDR_W-1:0] wr_addr_c;
  logic [DATA_W-1:0] wr_data_c;

  logic [DATA_W-1:0] b0_rd_a, b0_rd_b, b1_rd_a, b1_rd_b;

`ifdef FB_CLEAR_ON_SWAP_EN
  localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
`endif

  // Swap FSM next-state logic.
  always_comb begin
    state_d     = state_q;
    front_sel_d = front_sel;
    swap_ack_d  = 1'b0;
    do_swap_c   = 1'b0;
`ifdef FB_CLEAR_ON_SWAP_EN
    clr_cnt_d   = clr_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (swap_req) begin
          if (frame_sync) do_swap_c = 1'b1;
          else            state_d   = ST_WAIT_SYNC;
        end
      end
      ST_WAIT_SYNC: begin
        if (!swap_req)       state_d   = ST_IDLE;
        else if (frame_sync) do_swap_c = 1'b1;
      end
`ifdef FB_CLEAR_ON_SWAP_EN
      ST_CLEAR: begin
        clr_cnt_d = clr_cnt_q + ADDR_W'(1);
        if (clr_cnt_q == CLR_LAST) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    if (do_swap_c) begin
      front_sel_d = ~front_sel;
      swap_ack_d  = 1'b1;
`ifdef FB_CLEAR_ON_SWAP_EN
      state_d     = ST_CLEAR;
      clr_cnt_d   = '0;
`else
      state_d     = ST_IDLE;
`endif
    end
  end

  // State and registered outputs; read mux select travels with the read address.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      front_sel <= INIT_SEL;
      swap_ack  <= 1'b0;
      rd_sel_q  <= INIT_SEL;
      a_rdata   <= '0;
      b_rdata   <= '0;
`ifdef FB_CLEAR_ON_SWAP_EN
      clr_cnt_q <= '0;
      clr_busy  <= 1'b0;
      a_ready   <= 1'b1;
`endif
    end else begin
      state_q   <= state_d;
      front_sel <= front_sel_d;
      swap_ack  <= swap_ack_d;
      rd_sel_q  <= front_sel;
      a_rdata   <= rd_sel_q ? b1_rd_a : b0_rd_a;
      b_rdata   <= rd_sel_q ? b1_rd_b : b0_rd_b;
`ifdef FB_CLEAR_ON_SWAP_EN
      clr_cnt_q <= clr_cnt_d;
      clr_busy  <= (state_d == ST_CLEAR);
      a_ready   <= (state_d != ST_CLEAR);
`endif
    end
  end

`ifndef FB_CLEAR_ON_SWAP_EN
  assign clr_busy = 1'b0;
  assign a_ready  = 1'b1;
`endif

  // Back-bank write source: the sweep owns the port while clearing.
  always_comb begin
    wr_en_c   = a_we & a_ready;
    wr_addr_c = a_addr;
    wr_data_c = a_wdata;
`ifdef FB_CLEAR_ON_SWAP_EN
    if (state_q == ST_CLEAR) begin
      wr_en_c   = 1'b1;
      wr_addr_c = clr_cnt_q;
      wr_data_c = '0;
    end
`endif
  end

  fb_dp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_bank0 (
    .clk    (clk),
    .we     (wr_en_c & front_sel),
    .waddr  (wr_addr_c),
    .wdata  (wr_data_c),
    .raddr0 (a_addr),
    .rdata0 (b0_rd_a),
    .raddr1 (b_addr),
    .rdata1 (b0_rd_b)
  );

  fb_dp_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_bank1 (
    .clk    (clk),
    .we     (wr_en_c & ~front_sel),
    .waddr  (wr_addr_c),
    .wdata  (wr_data_c),
    .raddr0 (a_addr),
    .rdata0 (b1_rd_a),
    .raddr1 (b_addr),
    .rdata1 (b1_rd_b)
  );

endmodule

// File: tb/tb_dbuf_framebuffer_ctrl.sv
// Self-checking bench for dbuf_framebuffer_ctrl: directed table, corner sequences, random vs. model.
module tb_dbuf_framebuffer_ctrl;

  localparam int unsigned DW   = 4;
  localparam int unsigned AW   = 7;
  localparam int unsigned DEP  = 100;
  localparam bit          INIT = 1'b0;
`ifdef FB_CLEAR_ON_SWAP_EN
  localparam bit CLR_EN = 1'b1;
`else
  localparam bit CLR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_we;
  logic          a_ready;
  logic [DW-1:0] a_rdata;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_rdata;
  logic          swap_req;
  logic          frame_sync;
  logic          swap_ack;
  logic          front_sel;
  logic          clr_busy;

  always #5 clk = ~clk;

  dbuf_framebuffer_ctrl #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .INIT_SEL(INIT)) dut (
    .clk        (clk),
    .rst        (rst),
    .a_addr     (a_addr),
    .a_wdata    (a_wdata),
    .a_we       (a_we),
    .a_ready    (a_ready),
    .a_rdata    (a_rdata),
    .b_addr     (b_addr),
    .b_rdata    (b_rdata),
    .swap_req   (swap_req),
    .frame_sync (frame_sync),
    .swap_ack   (swap_ack),
    .front_sel  (front_sel),
    .clr_busy   (clr_busy)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: two plain arrays plus a known-contents map.
  int unsigned m_mem [2][DEP];
  bit          m_kn  [2][DEP];
  bit          m_front, m_clr;
  int          m_idx;
  int          st_a, st_b, e_a, e_b;
  bit          st_a_kn, st_b_kn, e_a_kn, e_b_kn, e_ack;

  typedef struct {
    bit req; bit sync; bit we; int aa; int wd; int ba;
    bit chk_b; int exp_b; bit exp_ack; bit exp_front;
  } vec_t;
  vec_t vt [9];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_front = INIT; m_clr = 1'b0; m_idx = 0;
    st_a_kn = 1'b0; st_b_kn = 1'b0;
    e_a = 0; e_b = 0; e_a_kn = 1'b1; e_b_kn = 1'b1; e_ack = 1'b0;
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < int'(DEP); j++) m_kn[k][j] = 1'b0;
  endtask

  task automatic model_step(input bit req, input bit sync, input bit we,
                            input int aa, input int wd, input int ba);
    bit was_clr, fr, sw;
    was_clr = m_clr;
    fr      = m_front;
    e_a = st_a; e_a_kn = st_a_kn;
    e_b = st_b; e_b_kn = st_b_kn;
    if (aa >= int'(DEP)) begin st_a = 0; st_a_kn = 1'b1; end
    else begin st_a = int'(m_mem[fr][aa]); st_a_kn = m_kn[fr][aa]; end
    if (ba >= int'(DEP)) begin st_b = 0; st_b_kn = 1'b1; end
    else begin st_b = int'(m_mem[fr][ba]); st_b_kn = m_kn[fr][ba]; end
    if (we && !was_clr && aa < int'(DEP)) begin
      m_mem[!fr][aa] = wd; m_kn[!fr][aa] = 1'b1;
    end
    if (was_clr) begin
      m_mem[!fr][m_idx] = 0; m_kn[!fr][m_idx] = 1'b1;
      m_idx++;
      if (m_idx == int'(DEP)) m_clr = 1'b0;
    end
    sw = !was_clr && req && sync;
    if (sw) begin
      m_front = !m_front;
      if (CLR_EN) begin m_clr = 1'b1; m_idx = 0; end
    end
    e_ack = sw;
  endtask

  task automatic compare_all();
    chk("swap_ack",  int'(swap_ack),  int'(e_ack));
    chk("front_sel", int'(front_sel), int'(m_front));
    chk("clr_busy",  int'(clr_busy),  int'(m_clr));
    chk("a_ready",   int'(a_ready),   int'(!m_clr));
    if (e_a_kn) chk("a_rdata", int'(a_rdata), e_a);
    if (e_b_kn) chk("b_rdata", int'(b_rdata), e_b);
  endtask

  task automatic cycle(input bit req, input bit sync, input bit we,
                       input int aa, input int wd, input int ba);
    swap_req = req; frame_sync = sync; a_we = we;
    a_addr = AW'(aa); a_wdata = DW'(wd); b_addr = AW'(ba);
    model_step(req, sync, we, aa, wd, ba);
    @(posedge clk); #1;
    compare_all();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, 0, 0, 0);
  endtask

  task automatic wait_ready();
    for (int i = 0; i < int'(DEP) + 5 && m_clr; i++) idle();
    if (m_clr) chk("wait_ready_timeout", 1, 0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_a_rdata"},   int'(a_rdata),   0);
    chk({tag, "_b_rdata"},   int'(b_rdata),   0);
    chk({tag, "_swap_ack"},  int'(swap_ack),  0);
    chk({tag, "_front_sel"}, int'(front_sel), int'(INIT));
    chk({tag, "_clr_busy"},  int'(clr_busy),  0);
    chk({tag, "_a_ready"},   int'(a_ready),   1);
  endtask

  initial begin
    int n;
    bit req_r;
    rst = 1'b0; swap_req = 1'b0; frame_sync = 1'b0; a_we = 1'b0;
    a_addr = '0; a_wdata = '0; b_addr = '0;
    model_reset();
    st_a = 0; st_b = 0;

    // write 5=1, cancel a pending request, then swap with a write on the swap cycle
    vt[0] = '{1'b0, 1'b0, 1'b1, 5, 1, 5, 1'b0, 0, 1'b0, 1'b0};
    vt[1] = '{1'b1, 1'b0, 1'b0, 0, 0, 5, 1'b0, 0, 1'b0, 1'b0};
    vt[2] = '{1'b1, 1'b0, 1'b0, 0, 0, 5, 1'b0, 0, 1'b0, 1'b0};
    vt[3] = '{1'b0, 1'b0, 1'b0, 0, 0, 5, 1'b0, 0, 1'b0, 1'b0};
    vt[4] = '{1'b0, 1'b1, 1'b0, 0, 0, 5, 1'b0, 0, 1'b0, 1'b0};
    vt[5] = '{1'b1, 1'b1, 1'b1, 9, 7, 5, 1'b0, 0, 1'b1, 1'b1};
    vt[6] = '{1'b0, 1'b0, 1'b0, 0, 0, 5, 1'b0, 0, 1'b0, 1'b1};
    vt[7] = '{1'b0, 1'b0, 1'b0, 0, 0, 9, 1'b1, 1, 1'b0, 1'b1};
    vt[8] = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 1'b1, 7, 1'b0, 1'b1};

    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b1;

    for (int i = 0; i < 9; i++) begin
      cycle(vt[i].req, vt[i].sync, vt[i].we, vt[i].aa, vt[i].wd, vt[i].ba);
      chk($sformatf("vec%0d_ack", i),   int'(swap_ack),  int'(vt[i].exp_ack));
      chk($sformatf("vec%0d_front", i), int'(front_sel), int'(vt[i].exp_front));
      if (vt[i].chk_b) chk($sformatf("vec%0d_b", i), int'(b_rdata), vt[i].exp_b);
    end

    // read in flight across a swap returns old-front data
    wait_ready();
    cycle(1'b0, 1'b0, 1'b1, 12, 4, 0);
    cycle(1'b1, 1'b1, 1'b0, 0, 0, 9);
    chk("swap2_ack", int'(swap_ack), 1);
    cycle(1'b0, 1'b0, 1'b0, 0, 0, 12);
    chk("old_front_read", int'(b_rdata), 7);
    idle();
    chk("new_front_read", int'(b_rdata), 4);

    // long request without frame_sync, then sync
    wait_ready();
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 0, 0, 0);
      chk("no_sync_ack", int'(swap_ack), 0);
    end
    cycle(1'b1, 1'b1, 1'b0, 0, 0, 0);
    chk("sync_ack", int'(swap_ack), 1);
    chk("sync_front", int'(front_sel), 1);

`ifdef FB_CLEAR_ON_SWAP_EN
    n = clr_busy ? 1 : 0;
    for (int i = 0; i < int'(DEP) + 10 && clr_busy; i++) begin
      idle();
      if (clr_busy) n++;
    end
    chk("clear_len", n, int'(DEP));
    cycle(1'b1, 1'b1, 1'b0, 0, 0, 0);
    for (int i = 0; i <= int'(DEP); i++) begin
      cycle(1'b0, 1'b0, 1'b0, 0, 0, (i < int'(DEP)) ? i : 0);
      if (i >= 1) chk($sformatf("cleared_word%0d", i - 1), int'(b_rdata), 0);
    end
`else
    idle();
`endif

    // out-of-range write dropped and read returns zero; last valid word kept
    wait_ready();
    cycle(1'b0, 1'b0, 1'b1, int'(DEP), 1, 0);
    cycle(1'b0, 1'b0, 1'b1, int'(DEP) - 1, 3, 0);
    cycle(1'b1, 1'b1, 1'b0, 0, 0, 0);
    cycle(1'b0, 1'b0, 1'b0, int'(DEP), 0, int'(DEP) - 1);
    cycle(1'b0, 1'b0, 1'b0, int'(DEP) - 1, 0, int'(DEP));
    chk("oob_a_read", int'(a_rdata), 0);
    chk("last_b_read", int'(b_rdata), 3);
    idle();
    chk("last_a_read", int'(a_rdata), 3);
    chk("oob_b_read", int'(b_rdata), 0);

    // reset asserted shortly after a swap (mid-sweep when clearing is built in)
    wait_ready();
    cycle(1'b1, 1'b1, 1'b0, 0, 0, 0);
    repeat (3) idle();
    #2 rst = 1'b0;
    #1;
    check_reset_values("mid_reset");
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    // randomized traffic against the model
    req_r = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) req_r = ~req_r;
      cycle(req_r, ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1),
            int'($urandom_range(0, DEP + 15)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, DEP + 15)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
